// File: rtl/switch_debounce_edge_if.sv
// Switch front-end bus: raw switch inputs toward the debouncer, clean level and
// edge pulses back out, plus a per-channel FSM state tap for observation.
//
// Signalling: there is no valid/ready handshake on this bus. sw is sampled on
// every s_clk posedge with no timing relationship assumed; o_level, o_press,
// o_release and dbg_pending are registered and valid every cycle. A pulse on
// o_press/o_release is exactly one cycle wide and must be consumed in that cycle.
interface switch_debounce_edge_if #(
   parameter int NUM_SW = 1
);
   logic [NUM_SW-1:0] sw;
   logic [NUM_SW-1:0] o_level;
   logic [NUM_SW-1:0] o_press;
   logic [NUM_SW-1:0] o_release;
   logic [NUM_SW-1:0] dbg_pending;

   modport master (
      output sw,
      input  o_level,
      input  o_press,
      input  o_release,
      input  dbg_pending
   );

   modport slave (
      input  sw,
      output o_level,
      output o_press,
      output o_release,
      output dbg_pending
   );
endinterface

// File: rtl/switch_debounce_edge.sv
// Multi-channel switch synchroniser + debouncer with registered press/release
// pulses. Each channel is independent: a synchroniser chain feeds a two-state
// FSM that accepts a new level only after DEBOUNCE_CYCLES consecutive cycles
// of disagreement with the current debounced level.
module switch_debounce_edge #(
   parameter int NUM_SW          = 1,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2
) (
   input logic                  s_clk,
   input logic                  rst,
   switch_debounce_edge_if.slave bus
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   logic [NUM_SW-1:0] level_w;
   logic [NUM_SW-1:0] press_w;
   logic [NUM_SW-1:0] release_w;
   logic [NUM_SW-1:0] pending_w;

   for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_out;
      state_t                 state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   press_q, press_d;
      logic                   release_q, release_d;

      // Synchroniser chain: shift the raw switch in, oldest stage is the output.
      always_ff @(posedge s_clk or posedge rst) begin
         if (rst) sync_q <= '0;
         else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sw[g]};
      end

      assign sync_out = sync_q[SYNC_STAGES-1];

      // FSM state, counter, level and pulse registers.
      always_ff @(posedge s_clk or posedge rst) begin
         if (rst) begin
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      // Next state: count consecutive mismatch cycles; commit and pulse on the
      // last one, drop back to STABLE silently if the input returns (bounce).
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state_q)
            ST_STABLE: begin
               cnt_d = '0;
               if (sync_out != level_q) begin
                  state_d = ST_PENDING;
                  cnt_d   = CW'(1);
               end
            end
            ST_PENDING: begin
               if (sync_out == level_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = ST_STABLE;
                  cnt_d     = '0;
                  level_d   = sync_out;
                  press_d   = sync_out;
                  release_d = ~sync_out;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
         endcase
      end

      assign level_w[g]   = level_q;
      assign press_w[g]   = press_q;
      assign release_w[g] = release_q;
      assign pending_w[g] = (state_q == ST_PENDING);
   end

   assign bus.o_level     = level_w;
   assign bus.o_press     = press_w;
   assign bus.o_release   = release_w;
   assign bus.dbg_pending = pending_w;

endmodule

// File: tb/tb_switch_debounce_edge.sv
// Directed bench for switch_debounce_edge with NUM_SW=2, DEBOUNCE_CYCLES=8,
// SYNC_STAGES=2. Inputs change on the falling edge; outputs are checked on the
// falling edge after each rising edge, with edge 1 the first rising edge that
// samples the new sw value. A clean change appears at edge 10.
module tb_switch_debounce_edge;

   logic s_clk;
   logic rst;
   int   n_total;
   int   n_bad;

   switch_debounce_edge_if #(.NUM_SW(2)) bus ();

   switch_debounce_edge #(
      .NUM_SW(2),
      .DEBOUNCE_CYCLES(8),
      .SYNC_STAGES(2)
   ) dut (
      .s_clk(s_clk),
      .rst(rst),
      .bus(bus)
   );

   // Clock.
   initial begin
      s_clk = 1'b0;
      forever #5 s_clk = ~s_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge s_clk);
      @(negedge s_clk);
   endtask

   // Step n edges; level is lvl_a before pulse_edge and lvl_b from it on;
   // pulses appear only on pulse_edge (0 = no pulse expected).
   task automatic run_expect(input string tag, input int n, input logic [1:0] lvl_a,
                             input logic [1:0] lvl_b, input int pulse_edge,
                             input logic [1:0] prs, input logic [1:0] rel);
      logic [1:0] e_lvl;
      logic [1:0] e_prs;
      logic [1:0] e_rel;
      for (int e = 1; e <= n; e++) begin
         tick();
         e_lvl = (pulse_edge != 0 && e >= pulse_edge) ? lvl_b : lvl_a;
         e_prs = (e == pulse_edge) ? prs : 2'b00;
         e_rel = (e == pulse_edge) ? rel : 2'b00;
         check({tag, "_lvl"}, 32'(bus.o_level), 32'(e_lvl));
         check({tag, "_prs"}, 32'(bus.o_press), 32'(e_prs));
         check({tag, "_rel"}, 32'(bus.o_release), 32'(e_rel));
         check({tag, "_excl"}, 32'(bus.o_press & bus.o_release), 32'd0);
      end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b1;
      bus.sw  = 2'b00;

      // Reset state.
      repeat (3) @(negedge s_clk);
      check("rst_lvl", 32'(bus.o_level), 32'd0);
      check("rst_prs", 32'(bus.o_press), 32'd0);
      check("rst_rel", 32'(bus.o_release), 32'd0);
      check("rst_pend", 32'(bus.dbg_pending), 32'd0);
      rst = 1'b0;

      // 1: idle, all-zero input.
      run_expect("idle", 50, 2'b00, 2'b00, 0, 2'b00, 2'b00);

      // 3: 5-cycle bounces never commit.
      for (int k = 0; k < 4; k++) begin
         bus.sw = 2'b01;
         run_expect("bnc_hi", 5, 2'b00, 2'b00, 0, 2'b00, 2'b00);
         bus.sw = 2'b00;
         run_expect("bnc_lo", 12, 2'b00, 2'b00, 0, 2'b00, 2'b00);
      end

      // 2: clean press on channel 0.
      bus.sw = 2'b01;
      run_expect("press0", 20, 2'b00, 2'b01, 10, 2'b01, 2'b00);

      // 4: clean release on channel 0.
      bus.sw = 2'b00;
      run_expect("rel0", 20, 2'b01, 2'b00, 10, 2'b00, 2'b01);

      // 5: reset while pending at count 5, then press after release of reset.
      bus.sw = 2'b01;
      run_expect("pend", 7, 2'b00, 2'b00, 0, 2'b00, 2'b00);
      check("pend_state", 32'(bus.dbg_pending), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_pend", 32'(bus.dbg_pending), 32'd0);
      check("arst_lvl", 32'(bus.o_level), 32'd0);
      @(negedge s_clk);
      rst = 1'b0;
      run_expect("post_rst", 20, 2'b00, 2'b01, 10, 2'b01, 2'b00);

      // Asynchronous clear of a committed level, then re-press after reset.
      rst = 1'b1;
      #1;
      check("arst_lvl1", 32'(bus.o_level), 32'd0);
      @(negedge s_clk);
      rst = 1'b0;
      run_expect("post_rst2", 20, 2'b00, 2'b01, 10, 2'b01, 2'b00);
      bus.sw = 2'b00;
      run_expect("rel0b", 20, 2'b01, 2'b00, 10, 2'b00, 2'b01);

      // 6: simultaneous press, then channel 1 alone.
      bus.sw = 2'b11;
      run_expect("both", 20, 2'b00, 2'b11, 10, 2'b11, 2'b00);
      bus.sw = 2'b01;
      run_expect("ch1_rel", 20, 2'b11, 2'b01, 10, 2'b00, 2'b10);
      bus.sw = 2'b11;
      run_expect("ch1_prs", 20, 2'b01, 2'b11, 10, 2'b10, 2'b00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
